image_zero_sub: RTL and testbench

Input-side zero-point stage for the image datapath. It takes packed unsigned 8-bit activations on a valid/ready stream and subtracts the frame's 8-bit input zero point from every lane. It emits signed 9-bit lanes to the convolution MAC array, tags the last beat of each frame, and buffers the stream so downstream stalls never drop data. It is the inverse of the output zero-add/ReLU stage, placed ahead of the conv window logic.

---
 rtl/image_zero_sub.sv | 165 ++++++++++++++++
 tb/tb_image_zero_sub.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_zero_sub.sv
// Input zero-point subtraction stage: unsigned 8-bit lanes minus the latched frame
// zero point, registered into S1 and buffered by a 3-entry fall-through FIFO.
`ifndef PICTURE_NUM
`define PICTURE_NUM 2
`endif
`ifndef WIDTH_DATA
`define WIDTH_DATA 8
`endif

module image_zero_sub #(
  parameter int CHANNEL_IN_NUM = 8,
  localparam int N  = `PICTURE_NUM * CHANNEL_IN_NUM,
  localparam int DW = `WIDTH_DATA,
  localparam int OW = `WIDTH_DATA + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [7:0]      zero_data_in,
  input  logic [15:0]     beat_num,
  input  logic [N*DW-1:0] data_in,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [N*OW-1:0] data_out,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_last,
  output logic            busy,
  output logic            done
);

  localparam int EW = N*OW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  state_t          state_r, state_s;
  logic            busy_r, done_r;
  logic [7:0]      zp_r;
  logic [15:0]     beats_left_r;
  logic [N*OW-1:0] sub_s, s1_data_r;
  logic            s1_valid_r, s1_last_r;
  logic [EW-1:0]   mem_r [3];
  logic [1:0]      wr_ptr_r, rd_ptr_r, count_r;
  logic            in_ready_s, in_hs_s, push_s, pop_s;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Per-lane 9-bit two's complement subtraction; range -255..255 needs no saturation
  always_comb begin
    sub_s = {(N*OW){1'b0}};
    for (int k = 0; k < N; k++) begin
      sub_s[k*OW +: OW] = {1'b0, data_in[k*DW +: DW]} - {1'b0, zp_r};
    end
  end

  // Handshakes; the credit check counts the beat still sitting in S1
  always_comb begin
    in_ready_s = (state_r == RUN) && (beats_left_r != 16'd0) &&
                 (({1'b0, count_r} + {2'b00, s1_valid_r}) < 3'd3);
    in_hs_s    = in_valid && in_ready_s;
    push_s     = s1_valid_r;
    pop_s      = (count_r != 2'd0) && out_ready;
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = (beat_num == 16'd0) ? DONE : RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (in_hs_s && (beats_left_r == 16'd1)) begin
          state_s = DRAIN;
        end else begin
          state_s = RUN;
        end
      end
      DRAIN: begin
        if (!s1_valid_r && (count_r == 2'd0)) begin
          state_s = DONE;
        end else begin
          state_s = DRAIN;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register, frame parameters and beat counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      zp_r         <= 8'd0;
      beats_left_r <= 16'd0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != IDLE);
      done_r  <= (state_s == DONE);
      if ((state_r == IDLE) && start) begin
        zp_r         <= zero_data_in;
        beats_left_r <= beat_num;
      end else if (in_hs_s) begin
        beats_left_r <= beats_left_r - 16'd1;
      end
    end
  end

  // S1 pipeline register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_data_r  <= {(N*OW){1'b0}};
      s1_last_r  <= 1'b0;
    end else begin
      s1_valid_r <= in_hs_s;
      if (in_hs_s) begin
        s1_data_r <= sub_s;
        s1_last_r <= (beats_left_r == 16'd1);
      end
    end
  end

  // Circular FIFO; storage is cleared on reset so the head reads zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        mem_r[i] <= {EW{1'b0}};
      end
      wr_ptr_r <= 2'd0;
      rd_ptr_r <= 2'd0;
      count_r  <= 2'd0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= {s1_last_r, s1_data_r};
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign in_ready  = in_ready_s;
  assign data_out  = mem_r[rd_ptr_r][N*OW-1:0];
  assign out_last  = mem_r[rd_ptr_r][N*OW];
  assign out_valid = (count_r != 2'd0);
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_image_zero_sub.sv
// Self-checking bench for image_zero_sub: directed frames with random data checked
// against an arithmetic reference queue.
`ifndef PICTURE_NUM
`define PICTURE_NUM 2
`endif
`ifndef WIDTH_DATA
`define WIDTH_DATA 8
`endif

module tb_image_zero_sub;
  localparam int N  = `PICTURE_NUM * 8;
  localparam int OW = 9;

  logic            clk = 1'b0;
  logic            rst, start, in_valid, out_ready;
  logic [7:0]      zero_data_in;
  logic [15:0]     beat_num;
  logic [N*8-1:0]  data_in;
  logic            in_ready, out_valid, out_last, busy, done;
  logic [N*OW-1:0] data_out;

  image_zero_sub #(.CHANNEL_IN_NUM(8)) dut (
    .clk(clk), .rst(rst), .start(start), .zero_data_in(zero_data_in),
    .beat_num(beat_num), .data_in(data_in), .in_valid(in_valid), .in_ready(in_ready),
    .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic last; logic [N*OW-1:0] data;} beat_t;

  int errors = 0, checks = 0, cyc = 0;
  beat_t exp_q[$];
  logic [7:0] zp_lat;
  int frame_beats, accepted, out_count, done_seen, done_tick;
  int first_in_tick, first_out_tick, last_out_tick, ready_gaps;
  beat_t last_out, held_prev;
  logic stall_prev = 1'b0;

  function automatic logic [N*OW-1:0] ref_sub(input logic [N*8-1:0] x, input logic [7:0] zp);
    logic [N*OW-1:0] r;
    int v;
    for (int k = 0; k < N; k++) begin
      v = int'(x[k*8 +: 8]) - int'(zp);
      r[k*OW +: OW] = v[8:0];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*8-1:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock: observe at the falling edge, update the model, return just after the rising edge
  task automatic tick();
    beat_t cur, e;
    @(negedge clk);
    cur = {out_last, data_out};
    if (stall_prev) begin
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_data", cur, held_prev);
    end
    stall_prev = out_valid && !out_ready;
    held_prev  = cur;
    if (done) begin
      done_seen++;
      done_tick = cyc;
    end
    if (busy && in_valid && !in_ready && accepted < frame_beats) ready_gaps++;
    if (out_valid && out_ready) begin
      chk("out_expected", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("out_beat", cur, e);
      end
      out_count++;
      last_out      = cur;
      last_out_tick = cyc;
      if (first_out_tick < 0) first_out_tick = cyc;
    end
    if (in_valid && in_ready) begin
      accepted++;
      e.data = ref_sub(data_in, zp_lat);
      e.last = (accepted == frame_beats);
      exp_q.push_back(e);
      if (first_in_tick < 0) first_in_tick = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic start_frame(input logic [7:0] zp, input int nb);
    for (int i = 0; i < 50 && busy; i++) tick();
    chk("idle_before_start", busy, 1'b0);
    in_valid = 1'b0;
    start = 1'b1; zero_data_in = zp; beat_num = nb[15:0];
    zp_lat = zp; frame_beats = nb; accepted = 0; out_count = 0; done_seen = 0;
    first_in_tick = -1; first_out_tick = -1; ready_gaps = 0;
    tick();
    start = 1'b0; beat_num = 16'($urandom); zero_data_in = 8'($urandom);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_seen == 0; i++) begin
      zero_data_in = 8'($urandom);
      tick();
    end
    chk("done_seen", done_seen > 0, 1'b1);
    tick();
    chk("done_one_pulse", done_seen, 1);
    chk("done_after_last_out", (done_tick - last_out_tick >= 1) && (done_tick - last_out_tick <= 2), 1'b1);
    chk("queue_drained", exp_q.size(), 0);
    chk("out_count", out_count, frame_beats);
  endtask

  task automatic run_frame(input logic [7:0] zp, input int nb, input int vpct, input int rpct);
    start_frame(zp, nb);
    for (int i = 0; i < 600 && done_seen == 0; i++) begin
      in_valid = (accepted < nb) && ($urandom_range(99) < vpct);
      data_in = rand_data();
      out_ready = ($urandom_range(99) < rpct);
      zero_data_in = 8'($urandom);
      tick();
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
    wait_done(20);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] pin [4];
    logic [8:0] pout [4];
    logic [N*8-1:0] vin;
    logic [N*OW-1:0] vexp;

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    zero_data_in = 8'd0; beat_num = 16'd0; data_in = '0;
    #12;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_data_out", data_out, '0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Arithmetic, single beat
    pin[0] = 8'h00; pin[1] = 8'h80; pin[2] = 8'hFF; pin[3] = 8'h10;
    pout[0] = 9'h180; pout[1] = 9'h000; pout[2] = 9'h07F; pout[3] = 9'h190;
    for (int k = 0; k < N; k++) begin
      vin[k*8 +: 8]   = pin[k % 4];
      vexp[k*OW +: OW] = pout[k % 4];
    end
    out_ready = 1'b1;
    start_frame(8'h80, 1);
    chk("busy_after_start", busy, 1'b1);
    chk("in_ready_after_start", in_ready, 1'b1);
    data_in = vin; in_valid = 1'b1;
    for (int i = 0; i < 10 && accepted < 1; i++) tick();
    in_valid = 1'b0;
    wait_done(20);
    chk("arith_data", last_out.data, vexp);
    chk("arith_last", last_out.last, 1'b1);

    // Lane order with zero point 0
    for (int k = 0; k < N; k++) begin
      vin[k*8 +: 8]    = 8'(k);
      vexp[k*OW +: OW] = 9'(k);
    end
    start_frame(8'h00, 1);
    data_in = vin; in_valid = 1'b1;
    for (int i = 0; i < 10 && accepted < 1; i++) tick();
    in_valid = 1'b0;
    wait_done(20);
    chk("lane_order", last_out.data, vexp);

    // Full throughput
    start_frame(8'($urandom), 64);
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 200 && done_seen == 0; i++) begin
      data_in = rand_data();
      tick();
    end
    in_valid = 1'b0;
    wait_done(20);
    chk("tput_no_gaps", ready_gaps, 0);
    chk("tput_first_latency", first_out_tick - first_in_tick, 2);
    chk("tput_consecutive", last_out_tick - first_out_tick, 63);
    chk("tput_last", last_out.last, 1'b1);

    // Backpressure with an ignored start and a changing zero point
    start_frame(8'h33, 16);
    in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      data_in = rand_data();
      start = (i == 5);
      beat_num = 16'd5;
      tick();
    end
    start = 1'b0;
    chk("bp_accepted", accepted, 3);
    chk("bp_in_ready", in_ready, 1'b0);
    chk("bp_out_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 100 && done_seen == 0; i++) begin
      in_valid = (accepted < 16);
      data_in = rand_data();
      tick();
    end
    in_valid = 1'b0;
    wait_done(20);

    // Empty frame
    start_frame(8'h55, 0);
    chk("empty_done", done, 1'b1);
    tick();
    chk("empty_done_drop", done, 1'b0);
    chk("empty_busy", busy, 1'b0);
    chk("empty_no_out", out_count, 0);

    // Random frames
    for (int f = 0; f < 3; f++) begin
      run_frame(8'($urandom), $urandom_range(20, 1), 70, 60);
    end

    // Reset mid-frame with two beats buffered
    start_frame(8'h21, 10);
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 30 && accepted < 5; i++) begin
      data_in = rand_data();
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    chk("pre_rst_out_valid", out_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_out_last", out_last, 1'b0);
    chk("arst_data_out", data_out, '0);
    chk("arst_in_ready", in_ready, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", done, 1'b0);
    exp_q.delete();
    stall_prev = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    run_frame(8'($urandom), 7, 100, 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
